md_seq_ctrl: RTL and testbench



---
 rtl/md_seq_ctrl.sv | 159 +++++++++++++++
 tb/tb_md_seq_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_seq_ctrl.sv
// Multiply/divide sequencer owning the architectural HI/LO registers.
// Optional MADD/MADDU/MSUB/MSUBU support is enabled by defining MD_SEQ_MADD_EN.
module md_seq_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {
    IDLE,
    RUN
  } stateT;

  localparam logic [4:0] MULT_LOAD = 5'(MULT_CYCLES - 1);
  localparam logic [4:0] DIV_LOAD  = 5'(DIV_CYCLES - 1);

  stateT       state, nextState;
  logic [4:0]  count, nextCount;
  logic [63:0] pending, nextPending;
  logic        pendingValid, nextPendingValid;
  logic [31:0] hiReg, loReg, nextHi, nextLo;
  logic        busyReg, doneReg, nextBusy, nextDone;

  logic [63:0] signedProd;
  logic [63:0] unsignedProd;
  logic        divByZero;
  logic [31:0] safeDivisor;
  logic [31:0] absA, absB;
  logic [31:0] magQuo, magRem;
  logic [31:0] sQuo, sRem;
  logic [31:0] uQuo, uRem;
  logic        opValid;
  logic        opIsDiv;
  logic [63:0] opResult;

  assign signedProd   = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
  assign unsignedProd = {32'b0, src_a} * {32'b0, src_b};

  // Signed divide is done on magnitudes so 0x80000000 / -1 wraps cleanly
  // instead of relying on host overflow behaviour; a zero divisor is
  // replaced by 1 and its result is never committed.
  assign divByZero   = (src_b == 32'd0);
  assign safeDivisor = divByZero ? 32'd1 : src_b;
  assign absA        = src_a[31] ? (32'd0 - src_a) : src_a;
  assign absB        = divByZero ? 32'd1 : (src_b[31] ? (32'd0 - src_b) : src_b);
  assign magQuo      = absA / absB;
  assign magRem      = absA % absB;
  assign sQuo        = (src_a[31] ^ src_b[31]) ? (32'd0 - magQuo) : magQuo;
  assign sRem        = src_a[31] ? (32'd0 - magRem) : magRem;
  assign uQuo        = src_a / safeDivisor;
  assign uRem        = src_a % safeDivisor;

  assign opIsDiv = (md_op == 3'd2) || (md_op == 3'd3);

`ifdef MD_SEQ_MADD_EN
  assign opValid = 1'b1;
`else
  assign opValid = ~md_op[2];
`endif

  always_comb begin
    opResult = 64'd0;
    case (md_op)
      3'd0: opResult = signedProd;
      3'd1: opResult = unsignedProd;
      3'd2: opResult = {sRem, sQuo};
      3'd3: opResult = {uRem, uQuo};
`ifdef MD_SEQ_MADD_EN
      3'd4: opResult = {hiReg, loReg} + signedProd;
      3'd5: opResult = {hiReg, loReg} + unsignedProd;
      3'd6: opResult = {hiReg, loReg} - signedProd;
      3'd7: opResult = {hiReg, loReg} - unsignedProd;
`endif
      default: opResult = 64'd0;
    endcase
  end

  // Next-state, counter and HI/LO update; busy/done are precomputed so the
  // outputs come straight from flops.
  always_comb begin
    nextState        = state;
    nextCount        = count;
    nextPending      = pending;
    nextPendingValid = pendingValid;
    nextHi           = hiReg;
    nextLo           = loReg;
    case (state)
      IDLE: begin
        if (start) begin
          if (opValid) begin
            nextState        = RUN;
            nextCount        = opIsDiv ? DIV_LOAD : MULT_LOAD;
            nextPending      = opResult;
            nextPendingValid = ~(opIsDiv && divByZero);
          end
        end else begin
          if (hi_we) nextHi = wdata;
          if (lo_we) nextLo = wdata;
        end
      end
      RUN: begin
        if (count == 5'd0) begin
          nextState        = IDLE;
          nextPendingValid = 1'b0;
          if (pendingValid) begin
            nextHi = pending[63:32];
            nextLo = pending[31:0];
          end
        end else begin
          nextCount = count - 5'd1;
        end
      end
      default: nextState = IDLE;
    endcase
    nextBusy = (nextState == RUN);
    nextDone = (nextState == RUN) && (nextCount == 5'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      count        <= 5'd0;
      pending      <= 64'd0;
      pendingValid <= 1'b0;
      hiReg        <= 32'd0;
      loReg        <= 32'd0;
      busyReg      <= 1'b0;
      doneReg      <= 1'b0;
    end else begin
      state        <= nextState;
      count        <= nextCount;
      pending      <= nextPending;
      pendingValid <= nextPendingValid;
      hiReg        <= nextHi;
      loReg        <= nextLo;
      busyReg      <= nextBusy;
      doneReg      <= nextDone;
    end
  end

  assign busy = busyReg;
  assign done = doneReg;
  assign hi   = hiReg;
  assign lo   = loReg;

endmodule

// File: tb/tb_md_seq_ctrl.sv
// Directed self-checking bench for md_seq_ctrl; MADD checks run only when
// MD_SEQ_MADD_EN is defined, otherwise md_op=4 must be ignored.
module tb_md_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int nVectors = 0;
  int nFails   = 0;
  logic allowBusyStart = 1'b0;

  md_seq_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .md_op (md_op),
    .src_a (src_a),
    .src_b (src_b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream gating must never present start while busy, except in the
  // collision scenario that deliberately does so.
  always @(negedge clk) begin
    if (rst_n && !allowBusyStart)
      assert (!(start && busy)) else $error("[TB] start asserted while busy");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic writeHiLo(input logic hw, input logic lw, input logic [31:0] data);
    hi_we = hw;
    lo_we = lw;
    wdata = data;
    step();
    hi_we = 1'b0;
    lo_we = 1'b0;
  endtask

  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    md_op = op;
    src_a = a;
    src_b = b;
  endtask

  task automatic test_reset();
    nVectors++;
    if ({busy, done} !== 2'b00) begin
      nFails++;
      $display("[TB] FAIL reset_busy_done got %b expected 00", {busy, done});
    end
    nVectors++;
    if ({hi, lo} !== 64'd0) begin
      nFails++;
      $display("[TB] FAIL reset_hilo got %h expected 0", {hi, lo});
    end
  endtask

  task automatic test_mthi_mtlo();
    writeHiLo(1'b1, 1'b0, 32'h11111111);
    nVectors++;
    if (hi !== 32'h11111111 || lo !== 32'h0) begin
      nFails++;
      $display("[TB] FAIL mthi got %h:%h expected 11111111:00000000", hi, lo);
    end
    writeHiLo(1'b0, 1'b1, 32'h22222222);
    nVectors++;
    if (hi !== 32'h11111111 || lo !== 32'h22222222) begin
      nFails++;
      $display("[TB] FAIL mtlo got %h:%h expected 11111111:22222222", hi, lo);
    end
    writeHiLo(1'b1, 1'b1, 32'h33333333);
    nVectors++;
    if (hi !== 32'h33333333 || lo !== 32'h33333333) begin
      nFails++;
      $display("[TB] FAIL mthi_mtlo_both got %h:%h expected 33333333:33333333", hi, lo);
    end
  endtask

  task automatic test_mult();
    launch(3'd0, 32'hFFFFFFFF, 32'd2);
    for (int k = 1; k <= 6; k++) begin
      step();
      start = 1'b0;
      nVectors++;
      if (busy !== (k <= 5) || done !== (k == 5)) begin
        nFails++;
        $display("[TB] FAIL mult_timing cycle %0d got busy=%b done=%b expected busy=%b done=%b",
                 k, busy, done, (k <= 5), (k == 5));
      end
    end
    nVectors++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFE) begin
      nFails++;
      $display("[TB] FAIL mult_result got %h:%h expected ffffffff:fffffffe", hi, lo);
    end
    launch(3'd1, 32'hFFFFFFFF, 32'd2);
    for (int k = 1; k <= 6; k++) begin
      step();
      start = 1'b0;
    end
    nVectors++;
    if (hi !== 32'h00000001 || lo !== 32'hFFFFFFFE) begin
      nFails++;
      $display("[TB] FAIL multu_result got %h:%h expected 00000001:fffffffe", hi, lo);
    end
  endtask

  task automatic test_div();
    launch(3'd2, 32'hFFFFFFF9, 32'd2);
    for (int k = 1; k <= 11; k++) begin
      step();
      start = 1'b0;
      nVectors++;
      if (busy !== (k <= 10) || done !== (k == 10)) begin
        nFails++;
        $display("[TB] FAIL div_timing cycle %0d got busy=%b done=%b expected busy=%b done=%b",
                 k, busy, done, (k <= 10), (k == 10));
      end
    end
    nVectors++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
      nFails++;
      $display("[TB] FAIL div_neg got %h:%h expected ffffffff:fffffffd", hi, lo);
    end
    launch(3'd3, 32'd7, 32'd2);
    for (int k = 1; k <= 11; k++) begin
      step();
      start = 1'b0;
    end
    nVectors++;
    if (hi !== 32'd1 || lo !== 32'd3) begin
      nFails++;
      $display("[TB] FAIL divu got %h:%h expected 00000001:00000003", hi, lo);
    end
    launch(3'd2, 32'h80000000, 32'hFFFFFFFF);
    for (int k = 1; k <= 11; k++) begin
      step();
      start = 1'b0;
    end
    nVectors++;
    if (hi !== 32'd0 || lo !== 32'h80000000) begin
      nFails++;
      $display("[TB] FAIL div_overflow got %h:%h expected 00000000:80000000", hi, lo);
    end
  endtask

  task automatic test_div_by_zero();
    writeHiLo(1'b1, 1'b0, 32'h11111111);
    writeHiLo(1'b0, 1'b1, 32'h22222222);
    launch(3'd3, 32'd1234, 32'd0);
    for (int k = 1; k <= 11; k++) begin
      step();
      start = 1'b0;
      nVectors++;
      if (busy !== (k <= 10) || done !== (k == 10)) begin
        nFails++;
        $display("[TB] FAIL divzero_timing cycle %0d got busy=%b done=%b expected busy=%b done=%b",
                 k, busy, done, (k <= 10), (k == 10));
      end
    end
    nVectors++;
    if (hi !== 32'h11111111 || lo !== 32'h22222222) begin
      nFails++;
      $display("[TB] FAIL divzero_hilo got %h:%h expected 11111111:22222222", hi, lo);
    end
  endtask

  task automatic test_collision();
    launch(3'd0, 32'd3, 32'd4);
    allowBusyStart = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      start = 1'b0;
      hi_we = 1'b0;
      if (k == 2) launch(3'd3, 32'd100, 32'd3);
      if (k == 3) begin
        hi_we = 1'b1;
        wdata = 32'hDEADBEEF;
      end
      nVectors++;
      if (busy !== (k <= 5) || done !== (k == 5)) begin
        nFails++;
        $display("[TB] FAIL collision_timing cycle %0d got busy=%b done=%b expected busy=%b done=%b",
                 k, busy, done, (k <= 5), (k == 5));
      end
    end
    allowBusyStart = 1'b0;
    nVectors++;
    if (hi !== 32'd0 || lo !== 32'd12) begin
      nFails++;
      $display("[TB] FAIL collision_result got %h:%h expected 00000000:0000000c", hi, lo);
    end
    launch(3'd1, 32'd5, 32'd6);
    lo_we = 1'b1;
    wdata = 32'hAAAAAAAA;
    step();
    start = 1'b0;
    lo_we = 1'b0;
    for (int k = 2; k <= 6; k++) step();
    nVectors++;
    if (hi !== 32'd0 || lo !== 32'd30) begin
      nFails++;
      $display("[TB] FAIL start_wins_write got %h:%h expected 00000000:0000001e", hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    launch(3'd0, 32'd7, 32'd9);
    for (int k = 1; k <= 6; k++) begin
      step();
      start = 1'b0;
    end
    nVectors++;
    if (hi !== 32'd0 || lo !== 32'd63) begin
      nFails++;
      $display("[TB] FAIL b2b_first got %h:%h expected 00000000:0000003f", hi, lo);
    end
    launch(3'd1, 32'h00010000, 32'h00010000);
    step();
    start = 1'b0;
    nVectors++;
    if (busy !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL b2b_accept got busy=%b expected 1", busy);
    end
    for (int k = 2; k <= 6; k++) step();
    nVectors++;
    if (hi !== 32'd1 || lo !== 32'd0) begin
      nFails++;
      $display("[TB] FAIL b2b_second got %h:%h expected 00000001:00000000", hi, lo);
    end
  endtask

  task automatic test_reset_mid_run();
    writeHiLo(1'b1, 1'b1, 32'h55555555);
    launch(3'd1, 32'd100, 32'd100);
    step();
    start = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    nVectors++;
    if ({busy, done} !== 2'b00 || {hi, lo} !== 64'd0) begin
      nFails++;
      $display("[TB] FAIL reset_mid_run got busy=%b done=%b hilo=%h expected all zero",
               busy, done, {hi, lo});
    end
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      nVectors++;
      if ({busy, done} !== 2'b00 || {hi, lo} !== 64'd0) begin
        nFails++;
        $display("[TB] FAIL reset_no_late_commit cycle %0d got busy=%b done=%b hilo=%h expected all zero",
                 k, busy, done, {hi, lo});
      end
    end
  endtask

`ifdef MD_SEQ_MADD_EN
  task automatic test_madd();
    writeHiLo(1'b1, 1'b0, 32'h0);
    writeHiLo(1'b0, 1'b1, 32'hFFFFFFFF);
    launch(3'd5, 32'd1, 32'd1);
    for (int k = 1; k <= 6; k++) begin
      step();
      start = 1'b0;
    end
    nVectors++;
    if (hi !== 32'd1 || lo !== 32'd0) begin
      nFails++;
      $display("[TB] FAIL maddu got %h:%h expected 00000001:00000000", hi, lo);
    end
    writeHiLo(1'b1, 1'b1, 32'h0);
    launch(3'd6, 32'd1, 32'd2);
    for (int k = 1; k <= 6; k++) begin
      step();
      start = 1'b0;
    end
    nVectors++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFE) begin
      nFails++;
      $display("[TB] FAIL msub got %h:%h expected ffffffff:fffffffe", hi, lo);
    end
  endtask
`else
  task automatic test_invalid_op();
    writeHiLo(1'b1, 1'b1, 32'h44444444);
    launch(3'd4, 32'd3, 32'd3);
    step();
    start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      nVectors++;
      if ({busy, done} !== 2'b00) begin
        nFails++;
        $display("[TB] FAIL invalid_op_busy cycle %0d got busy=%b done=%b expected 00", k, busy, done);
      end
      step();
    end
    nVectors++;
    if (hi !== 32'h44444444 || lo !== 32'h44444444) begin
      nFails++;
      $display("[TB] FAIL invalid_op_hilo got %h:%h expected 44444444:44444444", hi, lo);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    md_op = 3'd0;
    src_a = 32'd0;
    src_b = 32'd0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    wdata = 32'd0;
    #2;
    test_reset();
    #10;
    rst_n = 1'b1;
    step();
    test_mthi_mtlo();
    test_mult();
    test_div();
    test_div_by_zero();
    test_collision();
    test_back_to_back();
`ifdef MD_SEQ_MADD_EN
    test_madd();
`else
    test_invalid_op();
`endif
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nFails);
    $finish;
  end

endmodule
